// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, delays and sequencer state encoding for the MAC datapath
package mac_pkg;

    localparam int DEF_DW       = 4;
    localparam int DEF_RW       = 8;
    localparam int DEF_LW       = 4;
    // Shared with the MAC instance so operand and load timing stay aligned
    localparam int DEF_LOAD_DLY = 1;
    localparam int DEF_RES_DLY  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/mac_seq_ldpipe.sv
// rtl/mac_seq_ldpipe.sv - load-strobe delay line with an empty flag
module mac_seq_ldpipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout  = pipe_q[DEPTH-1];
    assign empty = ~|pipe_q;

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - operand-side sequencer feeding one MAC per dot product
// Optional shadow overflow detection (res_ovf) enabled by MAC_SEQUENCER_OVF_EN.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int RW       = DEF_RW,
    parameter int LW       = DEF_LW,
    parameter int LOAD_DLY = DEF_LOAD_DLY,
    parameter int RES_DLY  = DEF_RES_DLY
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          rd_en,
    output logic [LW-1:0] rd_addr,
    input  logic [DW-1:0] rd_w,
    input  logic [DW-1:0] rd_x,
    output logic [DW-1:0] mac_w,
    output logic [DW-1:0] mac_x,
    output logic          mac_load,
    output logic          mac_clear,
    input  logic [RW-1:0] mac_o,
    output logic [RW-1:0] res,
    output logic          res_valid,
    input  logic          res_ready
`ifdef MAC_SEQUENCER_OVF_EN
    ,
    output logic          res_ovf
`endif
);

    localparam int PD = 2 + LOAD_DLY;
    localparam int CW = $clog2(RES_DLY + 1) + 1;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] res_q, res_d;
    logic [DW-1:0] mac_w_q, mac_w_d;
    logic [DW-1:0] mac_x_q, mac_x_d;
    logic          rd_vld_q, rd_vld_d;
    logic          pipe_empty;
    logic          capture;

    mac_seq_ldpipe #(
        .DEPTH(PD)
    ) u_ldpipe (
        .clk  (clk),
        .clr  (clr),
        .din  (rd_en),
        .dout (mac_load),
        .empty(pipe_empty)
    );

    // Result is sampled only once every queued load has retired and mac_o has settled
    assign capture = (state_q == ST_DRAIN) && pipe_empty && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len != '0) ? ST_CLR : ST_HOLD;
            ST_CLR:   state_d = (len_q == LW'(1)) ? ST_DRAIN : ST_FEED;
            ST_FEED:  if (idx_q == len_q - LW'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (capture) state_d = ST_HOLD;
            ST_HOLD:  if (res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        rd_en     = (state_q == ST_CLR) || (state_q == ST_FEED);
        rd_addr   = (state_q == ST_FEED) ? idx_q : '0;
        mac_clear = (state_q == ST_CLR);
        res_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        len_d    = len_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rd_vld_d = rd_en;
        mac_w_d  = rd_vld_q ? rd_w : mac_w_q;
        mac_x_d  = rd_vld_q ? rd_x : mac_x_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d = len;
                    if (len == '0) res_d = '0;
                end
            end
            ST_CLR:  idx_d = LW'(1);
            ST_FEED: idx_d = idx_q + LW'(1);
            ST_DRAIN: begin
                if (!pipe_empty) begin
                    cnt_d = CW'(RES_DLY - 1);
                end else if (cnt_q == '0) begin
                    res_d = mac_o;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            len_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            mac_w_q  <= '0;
            mac_x_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            len_q    <= len_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            mac_w_q  <= mac_w_d;
            mac_x_q  <= mac_x_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign mac_w = mac_w_q;
    assign mac_x = mac_x_q;
    assign res   = res_q;

`ifdef MAC_SEQUENCER_OVF_EN
    localparam int SW = 2 * DW + LW;

    logic [SW-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (state_q == ST_IDLE || state_q == ST_CLR) begin
            shadow_d = '0;
        end else if (rd_vld_q) begin
            shadow_d = shadow_q + SW'(rd_w) * SW'(rd_x);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign res_ovf = (state_q == ST_HOLD) && (shadow_q > SW'((1 << RW) - 1));
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - scoreboard bench for mac_sequencer with buffer and MAC models
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       clr, start, res_ready;
    logic [3:0] len;
    logic       busy, rd_en, mac_load, mac_clear, res_valid;
    logic [3:0] rd_addr, rd_w, rd_x, mac_w, mac_x;
    logic [7:0] mac_o, res;
`ifdef MAC_SEQUENCER_OVF_EN
    logic       res_ovf;
`endif

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_w     (rd_w),
        .rd_x     (rd_x),
        .mac_w    (mac_w),
        .mac_x    (mac_x),
        .mac_load (mac_load),
        .mac_clear(mac_clear),
        .mac_o    (mac_o),
        .res      (res),
        .res_valid(res_valid),
        .res_ready(res_ready)
`ifdef MAC_SEQUENCER_OVF_EN
        ,
        .res_ovf  (res_ovf)
`endif
    );

    logic [3:0] bw [16];
    logic [3:0] bx [16];
    logic [3:0] w_r, x_r;
    logic [7:0] acc;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_w <= bw[rd_addr];
            rd_x <= bx[rd_addr];
        end
    end

    always @(posedge clk) begin
        w_r <= mac_w;
        x_r <= mac_x;
        if (clr || mac_clear) acc <= '0;
        else if (mac_load) acc <= acc + {4'b0, w_r} * {4'b0, x_r};
    end
    assign mac_o = acc;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        int         lat;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, first_cyc = 0, n_pop = 0, exp_pops = 0;
    int   n_load = 0, n_clear = 0, n_rd = 0, n_ovl = 0;
    logic vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (res_valid && !vld_prev) first_cyc = cyc;
        vld_prev = res_valid;
        if (mac_load) n_load++;
        if (mac_clear) n_clear++;
        if (rd_en) n_rd++;
        if (mac_load && mac_clear) n_ovl++;
        if (res_valid && res_ready) begin
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res", res, e.res);
                chk("latency", first_cyc - e.t0, e.lat);
`ifdef MAC_SEQUENCER_OVF_EN
                chk("res_ovf", res_ovf, e.ovf);
`endif
            end
            n_pop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_load = 0; n_clear = 0; n_rd = 0; n_ovl = 0;
    endtask

    task automatic do_start(input int n, input logic [7:0] er, input logic eo, input int lat);
        exp_t e;
        e.res = er; e.ovf = eo; e.lat = lat; e.t0 = cyc;
        exp_q.push_back(e);
        exp_pops++;
        start = 1'b1;
        len   = 4'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_pop < exp_pops && k < 200) begin
            tick();
            k++;
        end
        chk("result_done", n_pop, exp_pops);
    endtask

    task automatic set_el(input int i, input logic [3:0] w, input logic [3:0] x);
        bw[i] = w;
        bx[i] = x;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; len = '0; res_ready = 1'b1;
        for (int i = 0; i < 16; i++) set_el(i, 4'd0, 4'd0);
        tick(); tick(); tick();
        chk("rst_ctl", {busy, rd_en, mac_load, mac_clear, res_valid}, 0);
        chk("rst_data", {res, rd_addr, mac_w, mac_x}, 0);
        clr = 1'b0;
        tick();

        // len=3: 2*3 + 4*5 + 1*1 = 27
        set_el(0, 4'd2, 4'd3); set_el(1, 4'd4, 4'd5); set_el(2, 4'd1, 4'd1);
        clr_cnt();
        do_start(3, 8'h1B, 1'b0, 8);
        wait_done();
        chk("len3_loads", n_load, 3);
        chk("len3_clears", n_clear, 1);
        chk("len3_reads", n_rd, 3);
        chk("len3_overlap", n_ovl, 0);

        // len=15 of (15,15): 3375 mod 256 = 0x2F, overflows
        for (int i = 0; i < 15; i++) set_el(i, 4'd15, 4'd15);
        clr_cnt();
        do_start(15, 8'h2F, 1'b1, 20);
        wait_done();
        chk("len15_loads", n_load, 15);
        chk("len15_overlap", n_ovl, 0);

        // len=0 returns zero without touching MAC or buffers
        clr_cnt();
        do_start(0, 8'h00, 1'b0, 1);
        wait_done();
        chk("len0_reads", n_rd, 0);
        chk("len0_clears", n_clear, 0);
        chk("len0_loads", n_load, 0);

        // Consumer stall in HOLD: 3*3 + 2*5 = 19
        set_el(0, 4'd3, 4'd3); set_el(1, 4'd2, 4'd5);
        res_ready = 1'b0;
        clr_cnt();
        do_start(2, 8'h13, 1'b0, 7);
        for (int k = 0; k < 50 && !res_valid; k++) tick();
        chk("stall_valid", res_valid, 1);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1;
            len   = 4'd1;
            chk("stall_res", res, 8'h13);
            chk("stall_busy", busy, 1);
            tick();
        end
        start = 1'b0;
        res_ready = 1'b1;
        wait_done();
        chk("stall_clears", n_clear, 1);
        set_el(0, 4'd1, 4'd2);
        do_start(1, 8'h02, 1'b0, 6);
        chk("restart_busy", busy, 1);
        chk("restart_clear", mac_clear, 1);
        wait_done();

        // clr during second FEED cycle aborts the transfer
        for (int i = 0; i < 5; i++) set_el(i, 4'd5, 4'd6);
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_ctl", {busy, rd_en, mac_load, mac_clear, res_valid}, 0);
        chk("abort_data", {res, rd_addr, mac_w, mac_x}, 0);
        clr_cnt();
        for (int k = 0; k < 6; k++) tick();
        chk("abort_no_loads", n_load, 0);
        set_el(0, 4'd7, 4'd9);
        clr_cnt();
        do_start(1, 8'h3F, 1'b0, 6);
        wait_done();
        chk("len1_loads", n_load, 1);

        // Back-to-back: 1*2 + 3*4 = 14, then 5*5 + 6*6 = 61
        set_el(0, 4'd1, 4'd2); set_el(1, 4'd3, 4'd4);
        clr_cnt();
        do_start(2, 8'h0E, 1'b0, 7);
        wait_done();
        set_el(0, 4'd5, 4'd5); set_el(1, 4'd6, 4'd6);
        do_start(2, 8'h3D, 1'b0, 7);
        wait_done();
        chk("b2b_clears", n_clear, 2);
        chk("b2b_loads", n_load, 4);
        chk("b2b_overlap", n_ovl, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
